alu_wb_rr_queue: RTL and testbench
==================================

// Module: alu_wb_rr_queue
// PURPOSE
//  Multi-channel ALU writeback queue: NUM_CH ALU pipes (SIMD/SIMF instances) each push
//  finished-instruction results into a private DEPTH-entry FIFO; one round-robin arbiter
//  presents a single head entry to the RFA, which pops it via serviced. Generalises the
//  single-channel, fixed-depth ALU writeback queue: parametric channels/depth/width,
//  per-channel credit-style ready, fair arbitration, overflow detection, occupancy export.
// PARAMETERS
//  NUM_CH     2     number of ALU channels (>=1)
//  DEPTH      4     entries per channel FIFO (power of 2, >=2)
//  PAYLOAD_W  2265  packed result: vgpr data, sgpr data, vcc value, wr mask, dest addrs, wr enables
//  WFID_W     6     wavefront id width
//  PC_W       32    instruction PC width
// PORTS
//  clk                   in   1                    clock
//  rst                   in   1                    asynchronous, active-low reset
//  in_push               in   NUM_CH               per-channel instr_done (push strobe)
//  in_payload            in   NUM_CH*PAYLOAD_W     channel c at [c*PAYLOAD_W +: PAYLOAD_W]
//  in_wfid               in   NUM_CH*WFID_W        per-channel wavefront id
//  in_pc                 in   NUM_CH*PC_W          per-channel instruction PC (tracemon)
//  in_serviced           in   1                    RFA consumed the presented entry
//  out_ready             out  NUM_CH               channel may issue a new ALU instruction
//  out_valid             out  1                    rfa_queue_entry_valid
//  out_ch                out  $clog2(NUM_CH)|1     channel of presented entry
//  out_payload           out  PAYLOAD_W            head payload of out_ch
//  out_wfid              out  WFID_W               head wfid of out_ch
//  out_pc                out  PC_W                 head PC (tracemon_retire_pc)
//  out_count             out  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy
//  out_overflow          out  NUM_CH               sticky: push seen while channel full
// BEHAVIOUR
//  - Reset (rst=0, async): all counts/pointers 0, cur_ch=0, out_overflow=0, out_valid=0,
//    out_ready=all 1, out_count=0; out_payload/wfid/pc driven from RAM (don't-care, valid=0).
//  - FIFO c: write at wr_ptr on in_push[c]; pointers wrap modulo DEPTH; count 0..DEPTH.
//  - out_ready[c] = count[c] < DEPTH-1 (one-entry slack covers instruction already in
//    EX pipe when ready drops). Registered state only; no combinational path from in_push.
//  - Push when count[c]==DEPTH: data dropped, count unchanged, out_overflow[c] set until reset.
//  - Presentation: out_valid = (count[cur_ch]!=0); out_* = head of cur_ch (combinational
//    read of registered state). Push into empty selected channel -> out_valid next cycle.
//  - Pop: in_serviced & out_valid pops head of cur_ch. in_serviced with out_valid=0 ignored.
//  - Simultaneous push+pop on same channel: count unchanged, both pointers advance;
//    legal even when full (pop frees slot same cycle -> push accepted, no overflow).
//  - Arbiter (cur_ch register), evaluated every cycle:
//    * out_valid=1 and no pop: cur_ch holds (presented entry stable until serviced).
//    * pop, or cur_ch empty: cur_ch <= first channel with nonzero next-cycle count searching
//      cur_ch+1, cur_ch+2, ... wrapping, cur_ch last; if none, cur_ch unchanged.
//    * next-cycle counts include this cycle's pushes, so back-to-back service has no bubble.
//  - NUM_CH=1: arbiter degenerates, out_ch=0 constant.
//  - Per-channel FIFO order preserved; no ordering across channels.
//  - Reset mid-operation discards all entries; first cycle after release is idle.
// TESTING
//  1. Reset: rst=0 with pushes toggling -> out_valid=0, out_ready=2'b11, counts 0, overflow 0.
//  2. Single push ch0 (wfid=5, pc=0x100) at cycle t -> out_valid=1, out_ch=0, out_pc=0x100
//     at t+1; hold in_serviced=0 10 cycles -> outputs stable; serviced -> out_valid=0 next.
//  3. Fill: push ch1 3x (DEPTH=4) -> out_ready[1]=0 after count=3; 4th push -> count=4;
//     5th push -> dropped, out_overflow[1]=1, count stays 4.
//  4. Fairness: ch0,ch1 each 4 entries, serviced held 1 -> out_ch sequence 0,1,0,1,0,1,0,1,
//     PCs in per-channel push order, no idle cycle between entries.
//  5. Full + simultaneous push/pop on presented channel -> count stays 4, no overflow, new
//     entry appears at tail (seen after 3 further pops).
//  6. Async reset asserted mid-drain (counts 2/3) -> out_valid falls without clk edge;
//     after release all counts 0, cur_ch=0.

Source files
------------

// File: rtl/alu_wb_rr_queue.sv
// Multi-channel ALU writeback queue: per-channel FIFOs feeding the RFA
// through a round-robin arbiter with credit-style ready and overflow flags.
module alu_wb_rr_queue #(
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 2265,
    parameter int WFID_W    = 6,
    parameter int PC_W      = 32,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           in_push,
    input  logic [NUM_CH*PAYLOAD_W-1:0] in_payload,
    input  logic [NUM_CH*WFID_W-1:0]    in_wfid,
    input  logic [NUM_CH*PC_W-1:0]      in_pc,
    input  logic                        in_serviced,
    output logic [NUM_CH-1:0]           out_ready,
    output logic                        out_valid,
    output logic [CH_W-1:0]             out_ch,
    output logic [PAYLOAD_W-1:0]        out_payload,
    output logic [WFID_W-1:0]           out_wfid,
    output logic [PC_W-1:0]             out_pc,
    output logic [NUM_CH*CNT_W-1:0]     out_count,
    output logic [NUM_CH-1:0]           out_overflow
);

    logic [CNT_W-1:0]     cnt_q   [NUM_CH];
    logic [CNT_W-1:0]     cnt_d   [NUM_CH];
    logic [PTR_W-1:0]     wr_q    [NUM_CH];
    logic [PTR_W-1:0]     wr_d    [NUM_CH];
    logic [PTR_W-1:0]     rd_q    [NUM_CH];
    logic [PTR_W-1:0]     rd_d    [NUM_CH];
    logic [NUM_CH-1:0]    ovf_q;
    logic [NUM_CH-1:0]    ovf_d;
    logic [CH_W-1:0]      cur_q;
    logic [CH_W-1:0]      cur_d;
    logic [NUM_CH-1:0]    acc;
    logic [NUM_CH-1:0]    pop_c;
    logic                 pop;

    logic [PAYLOAD_W-1:0] pl_mem [NUM_CH][DEPTH];
    logic [WFID_W-1:0]    wf_mem [NUM_CH][DEPTH];
    logic [PC_W-1:0]      pc_mem [NUM_CH][DEPTH];

    assign out_valid    = (cnt_q[cur_q] != '0);
    assign out_ch       = cur_q;
    assign out_overflow = ovf_q;
    assign out_payload  = pl_mem[cur_q][rd_q[cur_q]];
    assign out_wfid     = wf_mem[cur_q][rd_q[cur_q]];
    assign out_pc       = pc_mem[cur_q][rd_q[cur_q]];
    assign pop          = in_serviced & out_valid;

    always_comb begin
        out_ready = '0;
        out_count = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            // One slot of slack for the instruction already in flight.
            out_ready[c] = (cnt_q[c] < CNT_W'(DEPTH - 1));
            out_count[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

    always_comb begin
        logic full;
        full  = 1'b0;
        pop_c = '0;
        acc   = '0;
        ovf_d = ovf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            full     = (cnt_q[c] == CNT_W'(DEPTH));
            pop_c[c] = pop && (cur_q == CH_W'(c));
            // A pop on a full channel frees the slot this same cycle.
            acc[c]   = in_push[c] && (!full || pop_c[c]);
            ovf_d[c] = ovf_q[c] | (in_push[c] & full & ~pop_c[c]);
            cnt_d[c] = cnt_q[c] + CNT_W'(acc[c]) - CNT_W'(pop_c[c]);
            wr_d[c]  = wr_q[c] + PTR_W'(acc[c]);
            rd_d[c]  = rd_q[c] + PTR_W'(pop_c[c]);
        end
    end

    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        cur_d = cur_q;
        if (pop || !out_valid) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                idx = (int'(cur_q) + i) % NUM_CH;
                if (!found && cnt_d[idx] != '0) begin
                    cur_d = CH_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
                wr_q[c]  <= '0;
                rd_q[c]  <= '0;
            end
            ovf_q <= '0;
            cur_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
                wr_q[c]  <= wr_d[c];
                rd_q[c]  <= rd_d[c];
            end
            ovf_q <= ovf_d;
            cur_q <= cur_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc[c]) begin
                pl_mem[c][wr_q[c]] <= in_payload[c*PAYLOAD_W +: PAYLOAD_W];
                wf_mem[c][wr_q[c]] <= in_wfid[c*WFID_W +: WFID_W];
                pc_mem[c][wr_q[c]] <= in_pc[c*PC_W +: PC_W];
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_rr_queue.sv
// Bench for alu_wb_rr_queue: directed table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_alu_wb_rr_queue;

    localparam int PLW = 2265;
    localparam int NW  = (PLW + 31) / 32;
    localparam int DEP = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        push;
    logic [2*PLW-1:0]  pl;
    logic [11:0]       wf;
    logic [63:0]       pcv;
    logic              svc;
    logic [1:0]        rdy;
    logic              vld;
    logic [0:0]        och;
    logic [PLW-1:0]    opl;
    logic [5:0]        owf;
    logic [31:0]       opc;
    logic [5:0]        ocnt;
    logic [1:0]        oovf;

    int n_cmp = 0;
    int n_err = 0;

    alu_wb_rr_queue #(
        .NUM_CH(2), .DEPTH(DEP), .PAYLOAD_W(PLW), .WFID_W(6), .PC_W(32)
    ) dut (
        .clk(clk), .rst(rst), .in_push(push), .in_payload(pl),
        .in_wfid(wf), .in_pc(pcv), .in_serviced(svc),
        .out_ready(rdy), .out_valid(vld), .out_ch(och),
        .out_payload(opl), .out_wfid(owf), .out_pc(opc),
        .out_count(ocnt), .out_overflow(oovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  push;
        logic        svc;
        logic        valid;
        logic        ch;
        logic [31:0] pc;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic [1:0]  rdy;
        logic [1:0]  ovf;
    } vec_t;

    typedef struct {
        logic [PLW-1:0] pl;
        logic [5:0]     wf;
        logic [31:0]    pc;
    } ent_t;

    vec_t tbl [14];
    ent_t mq [2][$];
    int   mcur;
    logic [1:0] movf;

    function automatic logic [PLW-1:0] mk_pl(input logic [31:0] s);
        logic [NW*32-1:0] t;
        for (int w = 0; w < NW; w++) t[w*32 +: 32] = s ^ (32'(w) * 32'h9E3779B9);
        return t[PLW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int c, input logic [31:0] pc, input logic [5:0] w);
        pcv[c*32 +: 32] = pc;
        wf[c*6 +: 6]    = w;
        pl[c*PLW +: PLW] = mk_pl(pc);
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        push = 2'b00;
        svc  = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic model_step(input logic [1:0] p, input logic s, input ent_t e0, input ent_t e1);
        bit was_empty;
        bit pp;
        was_empty = (mq[mcur].size() == 0);
        pp = s && !was_empty;
        if (pp) void'(mq[mcur].pop_front());
        if (p[0]) begin
            if (mq[0].size() < DEP) mq[0].push_back(e0);
            else movf[0] = 1'b1;
        end
        if (p[1]) begin
            if (mq[1].size() < DEP) mq[1].push_back(e1);
            else movf[1] = 1'b1;
        end
        if (pp || was_empty) begin
            for (int i = 1; i <= 2; i++) begin
                if (mq[(mcur + i) % 2].size() != 0) begin
                    mcur = (mcur + i) % 2;
                    break;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; push = 2'b00; svc = 1'b0;
        pl = '0; wf = '0; pcv = '0;

        // Reset held while pushes toggle.
        for (int i = 0; i < 4; i++) begin
            push = 2'(i + 1);
            step();
        end
        chk("rst_valid", 64'(vld), 64'd0);
        chk("rst_ready", 64'(rdy), 64'd3);
        chk("rst_count", 64'(ocnt), 64'd0);
        chk("rst_ovf", 64'(oovf), 64'd0);
        push = 2'b00;
        rst = 1'b1;
        step();
        chk("rst_idle", 64'(vld), 64'd0);

        // Single push, then hold unserviced.
        drv(0, 32'h100, 6'd5);
        push = 2'b01;
        step();
        push = 2'b00;
        chk("single_valid", 64'(vld), 64'd1);
        chk("single_ch", 64'(och), 64'd0);
        chk("single_pc", 64'(opc), 64'h100);
        chk("single_wfid", 64'(owf), 64'd5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_pc", 64'(opc), 64'h100);
            chk("hold_valid", 64'(vld), 64'd1);
        end
        svc = 1'b1;
        step();
        svc = 1'b0;
        chk("single_popped", 64'(vld), 64'd0);

        // Directed table: fill, overflow, full push+pop, drain.
        tbl[0]  = '{2'b01, 1'b0, 1'b1, 1'b0, 32'h100,  3'd1, 3'd0, 2'b11, 2'b00};
        tbl[1]  = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h100,  3'd1, 3'd0, 2'b11, 2'b00};
        tbl[2]  = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h0,    3'd0, 3'd0, 2'b11, 2'b00};
        tbl[3]  = '{2'b10, 1'b0, 1'b1, 1'b1, 32'h1103, 3'd0, 3'd1, 2'b11, 2'b00};
        tbl[4]  = '{2'b10, 1'b0, 1'b1, 1'b1, 32'h1103, 3'd0, 3'd2, 2'b11, 2'b00};
        tbl[5]  = '{2'b10, 1'b0, 1'b1, 1'b1, 32'h1103, 3'd0, 3'd3, 2'b01, 2'b00};
        tbl[6]  = '{2'b10, 1'b0, 1'b1, 1'b1, 32'h1103, 3'd0, 3'd4, 2'b01, 2'b00};
        tbl[7]  = '{2'b10, 1'b0, 1'b1, 1'b1, 32'h1103, 3'd0, 3'd4, 2'b01, 2'b10};
        tbl[8]  = '{2'b11, 1'b1, 1'b1, 1'b0, 32'h108,  3'd1, 3'd4, 2'b01, 2'b10};
        tbl[9]  = '{2'b00, 1'b1, 1'b1, 1'b1, 32'h1104, 3'd0, 3'd4, 2'b01, 2'b10};
        tbl[10] = '{2'b00, 1'b1, 1'b1, 1'b1, 32'h1105, 3'd0, 3'd3, 2'b01, 2'b10};
        tbl[11] = '{2'b00, 1'b1, 1'b1, 1'b1, 32'h1106, 3'd0, 3'd2, 2'b11, 2'b10};
        tbl[12] = '{2'b00, 1'b1, 1'b1, 1'b1, 32'h1108, 3'd0, 3'd1, 2'b11, 2'b10};
        tbl[13] = '{2'b00, 1'b1, 1'b0, 1'b1, 32'h0,    3'd0, 3'd0, 2'b11, 2'b10};
        do_reset();
        for (int r = 0; r < 14; r++) begin
            drv(0, 32'h100 + 32'(r), 6'(r));
            drv(1, 32'h1100 + 32'(r), 6'(r + 1));
            push = tbl[r].push;
            svc  = tbl[r].svc;
            step();
            chk($sformatf("tbl%0d_valid", r), 64'(vld), 64'(tbl[r].valid));
            if (tbl[r].valid) begin
                chk($sformatf("tbl%0d_ch", r), 64'(och), 64'(tbl[r].ch));
                chk($sformatf("tbl%0d_pc", r), 64'(opc), 64'(tbl[r].pc));
            end
            chk($sformatf("tbl%0d_c0", r), 64'(ocnt[2:0]), 64'(tbl[r].c0));
            chk($sformatf("tbl%0d_c1", r), 64'(ocnt[5:3]), 64'(tbl[r].c1));
            chk($sformatf("tbl%0d_rdy", r), 64'(rdy), 64'(tbl[r].rdy));
            chk($sformatf("tbl%0d_ovf", r), 64'(oovf), 64'(tbl[r].ovf));
        end
        push = 2'b00;
        svc  = 1'b0;

        // Fairness with back-to-back service.
        do_reset();
        drv(0, 32'h200, 6'd0);
        push = 2'b01;
        step();
        for (int k = 1; k < 4; k++) begin
            drv(0, 32'h200 + 32'(k), 6'd0);
            drv(1, 32'h300 + 32'(k - 1), 6'd1);
            push = 2'b11;
            step();
        end
        drv(1, 32'h303, 6'd1);
        push = 2'b10;
        step();
        push = 2'b00;
        chk("fair_count", 64'(ocnt), 64'h24);
        chk("fair_ready", 64'(rdy), 64'd0);
        svc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fair%0d_valid", i), 64'(vld), 64'd1);
            chk($sformatf("fair%0d_ch", i), 64'(och), 64'(i % 2));
            chk($sformatf("fair%0d_pc", i), 64'(opc),
                64'(((i % 2) ? 32'h300 : 32'h200) + 32'(i / 2)));
            step();
        end
        chk("fair_done", 64'(vld), 64'd0);
        svc = 1'b0;

        // Full channel, simultaneous push and pop.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drv(0, 32'h400 + 32'(k), 6'd2);
            push = 2'b01;
            step();
        end
        chk("full_c0", 64'(ocnt[2:0]), 64'd4);
        drv(0, 32'h4AA, 6'd3);
        svc = 1'b1;
        chk("full_head", 64'(opc), 64'h400);
        step();
        push = 2'b00;
        chk("pp_count", 64'(ocnt[2:0]), 64'd4);
        chk("pp_ovf", 64'(oovf), 64'd0);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("pp_pc%0d", k), 64'(opc), 64'(32'h400 + 32'(k)));
            step();
        end
        chk("pp_tail", 64'(opc), 64'h4AA);
        chk("pp_tail_wf", 64'(owf), 64'd3);
        step();
        chk("pp_empty", 64'(vld), 64'd0);
        svc = 1'b0;

        // Asynchronous reset mid-drain.
        do_reset();
        drv(0, 32'h500, 6'd0);
        drv(1, 32'h600, 6'd1);
        push = 2'b11;
        step();
        step();
        push = 2'b10;
        step();
        push = 2'b00;
        chk("mid_count", 64'(ocnt), 64'h1A);
        #3;
        rst = 1'b0;
        #1;
        chk("async_valid", 64'(vld), 64'd0);
        chk("async_count", 64'(ocnt), 64'd0);
        chk("async_ready", 64'(rdy), 64'd3);
        step();
        rst = 1'b1;
        step();
        chk("post_valid", 64'(vld), 64'd0);
        chk("post_ch", 64'(och), 64'd0);
        chk("post_count", 64'(ocnt), 64'd0);

        // Randomized traffic against the queue model.
        do_reset();
        mq[0].delete();
        mq[1].delete();
        mcur = 0;
        movf = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            ent_t e [2];
            int   sp;
            sp = ((n / 300) % 2 == 1) ? 80 : 35;
            for (int c = 0; c < 2; c++) begin
                e[c].pc = $urandom;
                e[c].wf = 6'($urandom);
                e[c].pl = mk_pl($urandom);
                push[c] = ($urandom_range(99) < 55);
                pcv[c*32 +: 32]  = e[c].pc;
                wf[c*6 +: 6]     = e[c].wf;
                pl[c*PLW +: PLW] = e[c].pl;
            end
            svc = ($urandom_range(99) < sp);
            chk("rnd_valid", 64'(vld), 64'(mq[mcur].size() != 0));
            if (mq[mcur].size() != 0) begin
                chk("rnd_ch", 64'(och), 64'(mcur));
                chk("rnd_pc", 64'(opc), 64'(mq[mcur][0].pc));
                chk("rnd_wfid", 64'(owf), 64'(mq[mcur][0].wf));
                chk("rnd_payload", 64'(opl == mq[mcur][0].pl), 64'd1);
            end
            chk("rnd_c0", 64'(ocnt[2:0]), 64'(mq[0].size()));
            chk("rnd_c1", 64'(ocnt[5:3]), 64'(mq[1].size()));
            chk("rnd_rdy0", 64'(rdy[0]), 64'(mq[0].size() < DEP - 1));
            chk("rnd_rdy1", 64'(rdy[1]), 64'(mq[1].size() < DEP - 1));
            chk("rnd_ovf", 64'(oovf), 64'(movf));
            @(posedge clk);
            model_step(push, svc, e[0], e[1]);
            #1;
        end
        push = 2'b00;
        svc  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
